// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH integer dividers of refclk with an ALIGN/SETTLE/LOCKED lock FSM and
// run-time ratio reconfiguration. Define CLK_DIV_PHASE_EN to add a per-channel start phase.
module clk_div_bank #(
  parameter int                      NUM_CH   = 3,
  parameter int                      DIV_W    = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd20, 8'd10, 8'd2},
  parameter int                      LOCK_DLY = 16
) (
  input  logic              refclk,
  input  logic              rst,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] clk_en,
  output logic              locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_DIV_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  output logic              cfg_err
);

  localparam logic [1:0]  ST_ALIGN    = 2'd0;
  localparam logic [1:0]  ST_SETTLE   = 2'd1;
  localparam logic [1:0]  ST_LOCKED   = 2'd2;
  localparam logic [3:0]  NUM_CH_L    = 4'(NUM_CH);
  localparam logic [15:0] SETTLE_LAST = 16'(LOCK_DLY - 1);

  logic [1:0]        state;
  logic [15:0]       settle_cnt;
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] outclk_nxt;
  logic [NUM_CH-1:0] clk_en_nxt;
  logic              accept;
  logic              ch_ok;
  logic              realign;
`ifdef CLK_DIV_PHASE_EN
  logic [DIV_W-1:0]  phase_q [NUM_CH];

  // Reduce the programmed phase so a counter never starts at or above its ratio.
  function automatic logic [DIV_W-1:0] start_cnt(input logic [DIV_W-1:0] phase,
                                                 input logic [DIV_W-1:0] d);
    if (d == '0) return '0;
    return phase % d;
  endfunction
`endif

  function automatic logic [DIV_W-1:0] run_cnt(input logic [DIV_W-1:0] cnt,
                                               input logic [DIV_W-1:0] d);
    if ((d == '0) || (cnt >= d - DIV_W'(1))) return '0;
    return cnt + DIV_W'(1);
  endfunction

  // High for the first ceil(D/2) counts; a disabled channel (D=0) stays low.
  function automatic logic is_high(input logic [DIV_W-1:0] cnt,
                                   input logic [DIV_W-1:0] d);
    logic [DIV_W:0] half;
    half = ({1'b0, d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return (d != '0) && ({1'b0, cnt} < half);
  endfunction

  assign cfg_ready = locked;
  assign accept    = cfg_valid && cfg_ready;
  assign ch_ok     = {1'b0, cfg_ch} < NUM_CH_L;
  assign realign   = accept && ch_ok;

  always_comb begin
    outclk_nxt = '0;
    clk_en_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = '0;
      if (state == ST_ALIGN) begin
`ifdef CLK_DIV_PHASE_EN
        cnt_nxt[i] = start_cnt(phase_q[i], div_q[i]);
`else
        cnt_nxt[i] = '0;
`endif
      end else if (!realign) begin
        cnt_nxt[i] = run_cnt(cnt_q[i], div_q[i]);
      end
      // The cycle after an accepted realign is ALIGN: outputs forced low there.
      if (!realign) begin
        outclk_nxt[i] = is_high(cnt_nxt[i], div_q[i]);
        clk_en_nxt[i] = (div_q[i] != '0) && (cnt_nxt[i] == div_q[i] - DIV_W'(1));
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_ALIGN;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_err    <= 1'b0;
      outclk     <= '0;
      clk_en     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
        cnt_q[i] <= '0;
`ifdef CLK_DIV_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      cfg_err <= accept && !ch_ok;
      outclk  <= outclk_nxt;
      clk_en  <= clk_en_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
        if (realign && (cfg_ch == 3'(i))) begin
          div_q[i] <= cfg_div;
`ifdef CLK_DIV_PHASE_EN
          phase_q[i] <= cfg_phase;
`endif
        end
      end
      case (state)
        ST_ALIGN: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        ST_LOCKED: begin
          if (realign) begin
            state  <= ST_ALIGN;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_ALIGN;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
